// File: rtl/serial_add_arb.sv
// Two-requester adder that time-shares one bit-serial full-adder slice.
// A round-robin arbiter grants one operation at a time. The operation runs
// LSB-first for WIDTH cycles, and the result is held until the consumer takes it.
module serial_add_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             last_grant_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;
  logic             res_id_q;

  logic             grant_vld;
  logic             grant_id;
  logic             bit_a;
  logic             bit_b;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] acc_nxt;

  // Round-robin grant. A tie goes to the requester that did not win last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && (state_q == IDLE) && (req0_valid || req1_valid)) begin
      grant_vld = 1'b1;
      if (req0_valid && req1_valid) begin
        grant_id = ~last_grant_q;
      end else begin
        grant_id = req1_valid;
      end
    end
    req0_ready = grant_vld & ~grant_id;
    req1_ready = grant_vld &  grant_id;
  end

  // Shared full-adder slice acting on the current bit index.
  always_comb begin
    bit_a            = a_q[idx_q];
    bit_b            = b_q[idx_q];
    sum_bit          = bit_a ^ bit_b ^ carry_q;
    carry_nxt        = ((bit_a ^ bit_b) & carry_q) | (bit_a & bit_b);
    acc_nxt          = acc_q;
    acc_nxt[idx_q]   = sum_bit;
  end

  // Control FSM, operand capture, serial accumulation and the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q          <= grant_id ? req1_a   : req0_a;
            b_q          <= grant_id ? req1_b   : req0_b;
            carry_q      <= grant_id ? req1_cin : req0_cin;
            idx_q        <= '0;
            last_grant_q <= grant_id;
            state_q      <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= carry_nxt;
          if (idx_q == LAST_IDX) begin
            res_sum_q   <= acc_nxt;
            res_cout_q  <= carry_nxt;
            res_id_q    <= last_grant_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule
